cordic_mmio: RTL

Memory-mapped front end for the CORDIC core on the TinyQV peripheral bus. It holds operands and configuration written by the CPU and launches the core with a one-cycle start pulse. It keeps mode and direction stable while the core iterates, captures out1/out2 on the core's done pulse, and raises a sticky done flag and interrupt. It sits directly upstream of the core and drives all of the core's inputs; it is also the sole consumer of the core's outputs.

---
 rtl/cordic_pkg.sv | 46 ++++
 rtl/cordic_mmio.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC MMIO front end: register byte offsets,
// CTRL/STATUS bit positions, mode encodings and the control FSM state type.
package cordic_pkg;

  // Register byte offsets; only bits [5:2] are decoded.
  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_OPA    = 6'h04;
  localparam logic [5:0] ADDR_OPB    = 6'h08;
  localparam logic [5:0] ADDR_RES    = 6'h0C;
  localparam logic [5:0] ADDR_STATUS = 6'h10;

  // CTRL bit positions
  localparam int unsigned CTRL_START      = 0;
  localparam int unsigned CTRL_IS_ROT     = 1;
  localparam int unsigned CTRL_MODE_LSB   = 2;
  localparam int unsigned CTRL_SHIFT_LSB  = 4;
  localparam int unsigned CTRL_IRQ_EN     = 8;
  localparam int unsigned CTRL_AUTO_START = 9;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_OVERRUN = 2;
  localparam int unsigned STAT_TIMEOUT = 3;

  // Mode encodings shared with the core
  localparam logic [1:0] CIRCULAR_MODE   = 2'd0;
  localparam logic [1:0] LINEAR_MODE     = 2'd1;
  localparam logic [1:0] HYPERBOLIC_MODE = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait
  } state_e;

  // Packed so that it maps directly onto CTRL[9:1].
  typedef struct packed {
    logic       auto_start;
    logic       irq_en;
    logic [3:0] frac_shift;
    logic [1:0] mode;
    logic       is_rotating;
  } ctrl_t;

endpackage

// File: rtl/cordic_mmio.sv
// Memory-mapped front end for the CORDIC core on the TinyQV peripheral bus.
// Holds operands/config, launches the core with a one-cycle start pulse,
// captures results on the core's done pulse and raises done/interrupt.
// Ports:
//   clk, rst_n (sync, active-low)
//   address/data_in/data_write_n/data_read_n/data_out/data_ready : bus
//   user_interrupt : STATUS.done & CTRL.irq_en
//   cd_start/cd_is_rotating/cd_mode/cd_frac_shift/cd_a/cd_b : to core
//   cd_out1/cd_out2/cd_done : from core
module cordic_mmio
  import cordic_pkg::*;
#(
  parameter int unsigned FIXED_WIDTH = 16,
  parameter int unsigned TIMEOUT     = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             address,
  input  logic [31:0]            data_in,
  input  logic [1:0]             data_write_n,
  input  logic [1:0]             data_read_n,
  output logic [31:0]            data_out,
  output logic                   data_ready,
  output logic                   user_interrupt,
  output logic                   cd_start,
  output logic                   cd_is_rotating,
  output logic [1:0]             cd_mode,
  output logic [3:0]             cd_frac_shift,
  output logic [FIXED_WIDTH-1:0] cd_a,
  output logic [FIXED_WIDTH-1:0] cd_b,
  input  logic [FIXED_WIDTH-1:0] cd_out1,
  input  logic [FIXED_WIDTH-1:0] cd_out2,
  input  logic                   cd_done
);

  // Abort on the last of TIMEOUT cycles spent in WAIT (counter starts at 0).
  localparam logic [4:0] WaitLast = 5'(TIMEOUT - 1);

  state_e                   state_q;
  ctrl_t                    ctrl_q;
  logic [FIXED_WIDTH-1:0]   opa_q, opb_q;
  logic [2*FIXED_WIDTH-1:0] res_q;
  logic                     done_q, overrun_q, timeout_q;
  logic [4:0]               wait_cnt_q;

  logic       wr_en, busy;
  logic [3:0] word;
  logic       sel_ctrl, sel_opa, sel_opb, sel_status;
  logic       start_req, cfg_write;

  assign wr_en      = (data_write_n == 2'b10);
  assign word       = address[5:2];
  assign sel_ctrl   = wr_en && (word == ADDR_CTRL[5:2]);
  assign sel_opa    = wr_en && (word == ADDR_OPA[5:2]);
  assign sel_opb    = wr_en && (word == ADDR_OPB[5:2]);
  assign sel_status = wr_en && (word == ADDR_STATUS[5:2]);
  assign busy       = (state_q != StIdle);
  assign cfg_write  = sel_ctrl || sel_opa || sel_opb;
  assign start_req  = (sel_ctrl && data_in[CTRL_START]) || (sel_opb && ctrl_q.auto_start);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
      cd_start   <= 1'b0;
    end else begin
      cd_start <= 1'b0;

      // Operands and config are frozen while a job runs.
      if (!busy) begin
        if (sel_ctrl) ctrl_q <= ctrl_t'(data_in[9:1]);
        if (sel_opa)  opa_q  <= data_in[FIXED_WIDTH-1:0];
        if (sel_opb)  opb_q  <= data_in[FIXED_WIDTH-1:0];
      end else if (cfg_write) begin
        overrun_q <= 1'b1;
      end

      // W1C first so that a same-cycle set below takes priority.
      if (sel_status && data_in[STAT_DONE])    done_q    <= 1'b0;
      if (sel_status && data_in[STAT_OVERRUN]) overrun_q <= 1'b0;
      if (sel_status && data_in[STAT_TIMEOUT]) timeout_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_req) begin
            done_q   <= 1'b0;
            cd_start <= 1'b1;
            state_q  <= StLaunch;
          end
        end
        StLaunch: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (cd_done) begin
            res_q   <= {cd_out2, cd_out1};
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (wait_cnt_q == WaitLast) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else if (wait_cnt_q != 5'h1f) begin
            wait_cnt_q <= wait_cnt_q + 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cd_is_rotating = ctrl_q.is_rotating;
  assign cd_mode        = ctrl_q.mode;
  assign cd_frac_shift  = ctrl_q.frac_shift;
  assign cd_a           = opa_q;
  assign cd_b           = opb_q;
  assign data_ready     = 1'b1;
  assign user_interrupt = done_q & ctrl_q.irq_en;

  always_comb begin
    data_out = '0;
    case (word)
      ADDR_CTRL[5:2]:   data_out = {22'd0, ctrl_q, 1'b0};
      ADDR_OPA[5:2]:    data_out[FIXED_WIDTH-1:0] = opa_q;
      ADDR_OPB[5:2]:    data_out[FIXED_WIDTH-1:0] = opb_q;
      ADDR_RES[5:2]:    data_out[2*FIXED_WIDTH-1:0] = res_q;
      ADDR_STATUS[5:2]: data_out = {28'd0, timeout_q, overrun_q, done_q, busy};
      default:          data_out = '0;
    endcase
  end

  // Reads have no side effects, so the read strobe is not needed.
  logic unused_bits;
  assign unused_bits = ^{data_read_n, address[1:0], data_in[31:16]};

endmodule
